debouncer_multi: RTL and testbench

Parametrised multi-channel push-button debouncer. It supersedes the single-channel single-pulse debouncer. Each channel gets:
- an input synchroniser
- N-sample stability filtering on a shared low-frequency tick
- a debounced level output
- one-clock press and release pulses
- optional auto-repeat of press pulses while a button is held

It sits between board push-buttons and the control FSMs, in the on-board 100 MHz clock domain.

---
 rtl/debouncer_multi.sv | 124 ++++++++++++
 tb/tb_debouncer_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel push-button debouncer with edge pulses and auto-repeat
module debouncer_multi #(
  parameter int NCH          = 4,
  parameter int TICK_MAX     = 100000,
  parameter int STABLE_CNT   = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] button,
  input  logic           repeat_en,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] press,
  output logic [NCH-1:0] rel,
  output logic           tick
);

  localparam int TW   = $clog2(TICK_MAX);
  localparam int SW   = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX + 1);

  logic [NCH-1:0]         sync1_q, sync1_d;
  logic [NCH-1:0]         sync2_q, sync2_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic [NCH-1:0][SW-1:0] stab_q, stab_d;
  logic [NCH-1:0]         level_q, level_d;
  logic [NCH-1:0]         prev_q, prev_d;
  logic [NCH-1:0][HW-1:0] hold_q, hold_d;
  logic [NCH-1:0]         rpt_q, rpt_d;
  logic [NCH-1:0]         fire_q, fire_d;
  logic [NCH-1:0]         press_q, press_d;
  logic [NCH-1:0]         rel_q, rel_d;

  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    if (cnt_q == TW'(TICK_MAX - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + TW'(1);
      tick_d = 1'b0;
    end

    level_d = level_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    fire_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      // Any sample that agrees with the current level restarts qualification.
      if (tick_q) begin
        if (sync2_q[i] == level_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == SW'(STABLE_CNT - 1)) begin
          level_d[i] = sync2_q[i];
          stab_d[i]  = '0;
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
      end

      if (!level_q[i] || !repeat_en) begin
        hold_d[i] = '0;
        rpt_d[i]  = 1'b0;
      end else if (tick_q) begin
        if (!rpt_q[i] && hold_q[i] == HW'(REPEAT_DELAY - 1)) begin
          fire_d[i] = 1'b1;
          rpt_d[i]  = 1'b1;
          hold_d[i] = '0;
        end else if (rpt_q[i] && hold_q[i] == HW'(REPEAT_RATE - 1)) begin
          fire_d[i] = 1'b1;
          hold_d[i] = '0;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end
    end

    // Repeat fires are dropped if the level fell or repeat was disabled meanwhile.
    prev_d  = level_q;
    press_d = (level_q & ~prev_q) | (fire_q & level_q & {NCH{repeat_en}});
    rel_d   = ~level_q & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      stab_q  <= '0;
      level_q <= '0;
      prev_q  <= '0;
      hold_q  <= '0;
      rpt_q   <= '0;
      fire_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      fire_q  <= fire_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - directed bench for debouncer_multi
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       repeat_en;
  logic [1:0] button;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] rel;
  logic       tick;

  int total = 0;
  int bad   = 0;
  int press_cnt[2];
  int rel_cnt[2];

  always #5 clk = ~clk;

  debouncer_multi #(
    .NCH(2), .TICK_MAX(4), .STABLE_CNT(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .repeat_en(repeat_en),
    .level(level), .press(press), .rel(rel), .tick(tick)
  );

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        press_cnt[c] += int'(press[c]);
        rel_cnt[c]   += int'(rel[c]);
      end
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
    end
  endtask

  // Leaves the bench just after the edge on which tick went high.
  task automatic wait_tick();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (tick !== 1'b1 && n < 16);
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL wait_tick: tick=%b required 1 within 16 clk", tick); end
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 2'b00; repeat_en = 1'b0;
    step(3);
    total++;
    if ({level, press, rel, tick} !== 7'b0)
      begin bad++; $display("FAIL reset_outputs: got %b required 0000000", {level, press, rel, tick}); end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      total++;
      if (tick !== ((k % 4) == 0))
        begin bad++; $display("FAIL tick_edge%0d: got %b required %b", k, tick, (k % 4) == 0); end
    end
    total++;
    if ({level, press, rel} !== 6'b0)
      begin bad++; $display("FAIL idle_outputs: got %b required 000000", {level, press, rel}); end
  endtask

  task automatic test_clean_press();
    clear_counts();
    wait_tick();
    button = 2'b01;
    step(12);
    total++; if (level !== 2'b00) begin bad++; $display("FAIL press_early: level=%b required 00", level); end
    step(1);
    total++; if (level !== 2'b01) begin bad++; $display("FAIL press_level: level=%b required 01", level); end
    total++; if (press !== 2'b00) begin bad++; $display("FAIL press_lat: press=%b required 00", press); end
    step(1);
    total++; if (press !== 2'b01) begin bad++; $display("FAIL press_pulse: press=%b required 01", press); end
    step(1);
    total++; if (press !== 2'b00) begin bad++; $display("FAIL press_width: press=%b required 00", press); end
    wait_tick();
    button = 2'b00;
    step(12);
    total++; if (level !== 2'b01) begin bad++; $display("FAIL rel_early: level=%b required 01", level); end
    step(1);
    total++; if (level !== 2'b00) begin bad++; $display("FAIL rel_level: level=%b required 00", level); end
    total++; if (rel !== 2'b00) begin bad++; $display("FAIL rel_lat: rel=%b required 00", rel); end
    step(1);
    total++; if (rel !== 2'b01) begin bad++; $display("FAIL rel_pulse: rel=%b required 01", rel); end
    step(1);
    total++; if (press_cnt[0] != 1 || rel_cnt[0] != 1)
      begin bad++; $display("FAIL clean_counts: press=%0d rel=%0d required 1 1", press_cnt[0], rel_cnt[0]); end
    total++; if (press_cnt[1] != 0 || rel_cnt[1] != 0)
      begin bad++; $display("FAIL ch1_quiet: press=%0d rel=%0d required 0 0", press_cnt[1], rel_cnt[1]); end
  endtask

  task automatic test_glitch();
    clear_counts();
    wait_tick();
    button = 2'b01;
    step(8);
    button = 2'b00;
    step(4);
    button = 2'b01;
    step(1);
    total++; if (level !== 2'b00) begin bad++; $display("FAIL glitch_reject: level=%b required 00", level); end
    step(11);
    total++; if (level !== 2'b00) begin bad++; $display("FAIL glitch_early: level=%b required 00", level); end
    step(1);
    total++; if (level !== 2'b01) begin bad++; $display("FAIL glitch_level: level=%b required 01", level); end
    step(5);
    total++; if (press_cnt[0] != 1) begin bad++; $display("FAIL glitch_press: count=%0d required 1", press_cnt[0]); end
    button = 2'b00;
    step(40);
    total++; if (level !== 2'b00 || rel_cnt[0] != 1)
      begin bad++; $display("FAIL glitch_release: level=%b rel=%0d required 00 1", level, rel_cnt[0]); end
  endtask

  task automatic test_auto_repeat();
    clear_counts();
    repeat_en = 1'b1;
    wait_tick();
    button = 2'b10;
    step(14);
    total++; if (press !== 2'b10) begin bad++; $display("FAIL rep_edge: press=%b required 10", press); end
    step(19);
    total++; if (press !== 2'b00) begin bad++; $display("FAIL rep_first_early: press=%b required 00", press); end
    step(1);
    total++; if (press !== 2'b10) begin bad++; $display("FAIL rep_first: press=%b required 10", press); end
    step(8);
    total++; if (press !== 2'b10) begin bad++; $display("FAIL rep_second: press=%b required 10", press); end
    step(26);
    total++; if (press_cnt[1] != 6) begin bad++; $display("FAIL rep_count: count=%0d required 6", press_cnt[1]); end
    repeat_en = 1'b0;
    step(40);
    total++; if (press_cnt[1] != 6) begin bad++; $display("FAIL rep_disable: count=%0d required 6", press_cnt[1]); end
    button = 2'b00;
    step(40);
    total++; if (rel_cnt[1] != 1 || level !== 2'b00)
      begin bad++; $display("FAIL rep_release: rel=%0d level=%b required 1 00", rel_cnt[1], level); end
    total++; if (press_cnt[0] != 0) begin bad++; $display("FAIL rep_ch0_quiet: count=%0d required 0", press_cnt[0]); end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    wait_tick();
    button = 2'b11;
    step(13);
    total++; if (level !== 2'b11) begin bad++; $display("FAIL sim_level: level=%b required 11", level); end
    step(1);
    total++; if (press !== 2'b11 || rel !== 2'b00)
      begin bad++; $display("FAIL sim_press: press=%b rel=%b required 11 00", press, rel); end
    wait_tick();
    button = 2'b00;
    step(14);
    total++; if (rel !== 2'b11 || press !== 2'b00)
      begin bad++; $display("FAIL sim_rel: rel=%b press=%b required 11 00", rel, press); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    wait_tick();
    button = 2'b01;
    step(10);
    rst = 1'b1;
    step(2);
    total++; if ({level, press, rel, tick} !== 7'b0)
      begin bad++; $display("FAIL mid_reset_outputs: got %b required 0000000", {level, press, rel, tick}); end
    rst = 1'b0;
    step(1);
    total++; if (press !== 2'b00) begin bad++; $display("FAIL mid_no_pulse: press=%b required 00", press); end
    step(11);
    total++; if (level !== 2'b00) begin bad++; $display("FAIL mid_requalify: level=%b required 00", level); end
    step(1);
    total++; if (level !== 2'b01) begin bad++; $display("FAIL mid_level: level=%b required 01", level); end
    step(1);
    total++; if (press !== 2'b01) begin bad++; $display("FAIL mid_press: press=%b required 01", press); end
    step(5);
    total++; if (press_cnt[0] != 1) begin bad++; $display("FAIL mid_count: count=%0d required 1", press_cnt[0]); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
